glb_host_dma: RTL and testbench

Host-side initiator for the accelerator top-level and its GLB.
- Preloads a GLB region (ifmap/filter/bias image) from a host input stream through the GLB write port.
- Pulses the accelerator start, waits for done, then drains the opsum region through the GLB read port to a host output stream.
- Sits between the testbench/host and the top-level's start/done plus GLB ports; it is the requester side of those interfaces.

---
 rtl/glb_host_dma_pkg.sv | 16 +
 rtl/glb_host_dma_if.sv | 46 ++++
 rtl/glb_dma_fifo2.sv | 58 +++++
 rtl/glb_host_dma.sv | 156 +++++++++++++++
 tb/tb_glb_host_dma.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/glb_host_dma_pkg.sv
// Shared definitions for the GLB host DMA: job FSM states and GLB access constants.
package glb_host_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StDrain,
    StFin
  } dma_state_e;

  localparam logic [3:0]  GLB_BYTE_EN_ALL = 4'hF;
  localparam int unsigned WORD_BYTES      = 4;

endpackage

// File: rtl/glb_host_dma_if.sv
// Bundle of every non-clock signal of glb_host_dma: job descriptor, host load/drain streams,
// accelerator start/done and the GLB write/read ports.
//   master : the DMA (requester of GLB and accelerator, consumer of descriptor and load stream)
//   slave  : the host / accelerator / GLB side
interface glb_host_dma_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [ADDR_W-1:0]    load_base;
  logic [LEN_W-1:0]     load_words;
  logic [ADDR_W-1:0]    drain_base;
  logic [LEN_W-1:0]     drain_words;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic                 acc_start;
  logic                 acc_done;
  logic [3:0]           glb_we;
  logic [ADDR_W-1:0]    glb_w_addr;
  logic [DATA_SIZE-1:0] glb_w_data;
  logic [3:0]           glb_re;
  logic [ADDR_W-1:0]    glb_r_addr;
  logic [DATA_SIZE-1:0] glb_r_data;
  logic                 busy;
  logic                 job_done;

  modport master (
    input  cfg_valid, load_base, load_words, drain_base, drain_words,
    input  in_valid, in_data, out_ready, acc_done, glb_r_data,
    output cfg_ready, in_ready, out_valid, out_data, acc_start,
    output glb_we, glb_w_addr, glb_w_data, glb_re, glb_r_addr, busy, job_done
  );

  modport slave (
    output cfg_valid, load_base, load_words, drain_base, drain_words,
    output in_valid, in_data, out_ready, acc_done, glb_r_data,
    input  cfg_ready, in_ready, out_valid, out_data, acc_start,
    input  glb_we, glb_w_addr, glb_w_data, glb_re, glb_r_addr, busy, job_done
  );
endinterface

// File: rtl/glb_dma_fifo2.sv
// Two-entry FIFO buffering GLB read data on its way to the host drain stream.
// Ports: push_i/push_data_i write, pop_i read (head on pop_data_o), count_o occupancy,
// empty_o. Push and pop in the same cycle are allowed; a push into a full FIFO without a
// pop and a pop from an empty FIFO are ignored.
module glb_dma_fifo2 #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] pop_data_o,
  output logic [1:0]           count_o,
  output logic                 empty_o
);
  logic [DataWidth-1:0] mem_q [2];
  logic [DataWidth-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == 2'd0);
endmodule

// File: rtl/glb_host_dma.sv
// Host-side initiator for the accelerator: preloads a GLB region from the host load stream,
// pulses acc_start, waits for acc_done, then drains the opsum region to the host output
// stream through a 2-entry FIFO with credit-based read issue.
// Ports: clk, rst (async, active-high); bus (glb_host_dma_if.master) carries the job
// descriptor, load/drain streams, acc_start/acc_done, GLB write/read ports, busy, job_done.
module glb_host_dma
  import glb_host_dma_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  glb_host_dma_if.master bus
);
  dma_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    load_base_q, load_base_d;
  logic [ADDR_W-1:0]    drain_base_q, drain_base_d;
  logic [LEN_W-1:0]     load_words_q, load_words_d;
  logic [LEN_W-1:0]     drain_words_q, drain_words_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]     pop_cnt_q, pop_cnt_d;
  logic                 rd_pend_q, rd_pend_d;  // read issued last cycle, data on glb_r_data now

  logic                 fifo_pop, fifo_empty;
  logic [1:0]           fifo_count;
  logic [DATA_SIZE-1:0] fifo_data;
  logic [2:0]           occupancy;
  logic                 credit_ok;

  glb_dma_fifo2 #(
    .DataWidth (DATA_SIZE)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (bus.glb_r_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_data;
  assign bus.busy      = (state_q != StIdle);
  assign fifo_pop      = bus.out_valid && bus.out_ready;

  // A slot freed by this cycle's pop may be reused immediately: the read issued now lands
  // in the FIFO only at the end of next cycle. This keeps one word per cycle streaming.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
  assign credit_ok = (occupancy < 3'd2);

  always_comb begin
    state_d        = state_q;
    load_base_d    = load_base_q;
    drain_base_d   = drain_base_q;
    load_words_d   = load_words_q;
    drain_words_d  = drain_words_q;
    idx_d          = idx_q;
    rd_idx_d       = rd_idx_q;
    pop_cnt_d      = pop_cnt_q;
    rd_pend_d      = 1'b0;
    bus.cfg_ready  = 1'b0;
    bus.in_ready   = 1'b0;
    bus.acc_start  = 1'b0;
    bus.job_done   = 1'b0;
    bus.glb_we     = 4'h0;
    bus.glb_w_addr = '0;
    bus.glb_w_data = '0;
    bus.glb_re     = 4'h0;
    bus.glb_r_addr = '0;

    unique case (state_q)
      StIdle: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          load_base_d   = {bus.load_base[ADDR_W-1:2], 2'b00};
          drain_base_d  = {bus.drain_base[ADDR_W-1:2], 2'b00};
          load_words_d  = bus.load_words;
          drain_words_d = bus.drain_words;
          idx_d         = '0;
          rd_idx_d      = '0;
          pop_cnt_d     = '0;
          state_d       = (bus.load_words != '0) ? StLoad : StStart;
        end
      end
      StLoad: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.glb_we     = GLB_BYTE_EN_ALL;
          bus.glb_w_addr = load_base_q + ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);
          bus.glb_w_data = bus.in_data;
          idx_d          = idx_q + LEN_W'(1);
          if (idx_q == load_words_q - LEN_W'(1)) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        bus.acc_start = 1'b1;
        state_d       = StWait;
      end
      StWait: begin
        if (bus.acc_done) begin
          state_d = (drain_words_q != '0) ? StDrain : StFin;
        end
      end
      StDrain: begin
        if (credit_ok && (rd_idx_q < drain_words_q)) begin
          bus.glb_re     = GLB_BYTE_EN_ALL;
          bus.glb_r_addr = drain_base_q + ADDR_W'(rd_idx_q) * ADDR_W'(WORD_BYTES);
          rd_idx_d       = rd_idx_q + LEN_W'(1);
          rd_pend_d      = 1'b1;
        end
        if (fifo_pop) begin
          pop_cnt_d = pop_cnt_q + LEN_W'(1);
          if (pop_cnt_q == drain_words_q - LEN_W'(1)) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        bus.job_done = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      load_base_q   <= '0;
      drain_base_q  <= '0;
      load_words_q  <= '0;
      drain_words_q <= '0;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      pop_cnt_q     <= '0;
      rd_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_base_q   <= load_base_d;
      drain_base_q  <= drain_base_d;
      load_words_q  <= load_words_d;
      drain_words_q <= drain_words_d;
      idx_q         <= idx_d;
      rd_idx_q      <= rd_idx_d;
      pop_cnt_q     <= pop_cnt_d;
      rd_pend_q     <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_glb_host_dma.sv
// Scoreboard bench for glb_host_dma: expected GLB writes, GLB reads and drained words are
// queued when a job is set up and checked by a negedge monitor as the DUT produces them.
module tb_glb_host_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glb_host_dma_if bus ();

  glb_host_dma u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_w_addr[$];
  logic [31:0] exp_w_data[$];
  logic [31:0] exp_r_addr[$];
  logic [31:0] exp_out[$];

  int we_cnt, re_cnt, pop_cnt, start_cnt, done_cnt;
  int first_we, last_we, first_re, last_re, first_pop, last_pop, done_cyc;

  // GLB image seen by the drain: each word is a function of its address.
  function automatic logic [31:0] glb_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // GLB read port model: one-cycle latency.
  always @(posedge clk) begin
    bus.glb_r_data <= (bus.glb_re == 4'hF) ? glb_word(bus.glb_r_addr) : 32'h0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.glb_we != 4'h0 || bus.glb_re != 4'h0)
        check_eq("we_re_excl", 32'(bus.glb_we != 4'h0 && bus.glb_re != 4'h0), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) check_eq("unexpected_pop", 32'd1, 32'd0);
        else check_eq("out_data", bus.out_data, exp_out.pop_front());
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (bus.glb_we != 4'h0) begin
        check_eq("glb_we_val", 32'(bus.glb_we), 32'hF);
        if (exp_w_addr.size() == 0) check_eq("unexpected_write", 32'd1, 32'd0);
        else begin
          check_eq("glb_w_addr", bus.glb_w_addr, exp_w_addr.pop_front());
          check_eq("glb_w_data", bus.glb_w_data, exp_w_data.pop_front());
        end
        we_cnt++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (bus.glb_re != 4'h0) begin
        check_eq("glb_re_val", 32'(bus.glb_re), 32'hF);
        if (exp_r_addr.size() == 0) check_eq("unexpected_read", 32'd1, 32'd0);
        else check_eq("glb_r_addr", bus.glb_r_addr, exp_r_addr.pop_front());
        re_cnt++;
        check_eq("rd_outstanding", 32'((re_cnt - pop_cnt) <= 2), 32'd1);
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
      end
      if (bus.acc_start) start_cnt++;
      if (bus.job_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_job(input logic [31:0] lb, input int lw, input logic [31:0] seed,
                         input logic [31:0] db, input int dw, input logic [3:0] rdy_pat,
                         input int done_dly, input int abort_after);
    logic [31:0] lb_al, db_al;
    int i;
    bit seen;
    lb_al = lb & 32'hFFFF_FFFC;
    db_al = db & 32'hFFFF_FFFC;
    we_cnt = 0; re_cnt = 0; pop_cnt = 0; start_cnt = 0; done_cnt = 0;
    first_we = -1; first_re = -1; first_pop = -1;
    last_we = -1; last_re = -1; last_pop = -1; done_cyc = -1;
    for (int j = 0; j < lw; j++) begin
      exp_w_addr.push_back(lb_al + 32'(4 * j));
      exp_w_data.push_back(seed * 32'(j + 1));
    end
    for (int j = 0; j < dw; j++) begin
      exp_r_addr.push_back(db_al + 32'(4 * j));
      exp_out.push_back(glb_word(db_al + 32'(4 * j)));
    end

    @(posedge clk); #1;
    bus.load_base   = lb;
    bus.load_words  = 16'(lw);
    bus.drain_base  = db;
    bus.drain_words = 16'(dw);
    bus.cfg_valid   = 1'b1;
    bus.out_ready   = rdy_pat[3];
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;

    i = 0;
    for (int k = 0; k < 100 && i < lw; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = seed * 32'(i + 1);
      @(negedge clk);
      if (bus.in_ready) i++;
      @(posedge clk); #1;
    end
    if (i < lw) check_eq("load_timeout", 32'(i), 32'(lw));
    bus.in_valid = 1'b0;

    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.acc_start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("acc_start_seen", 32'(seen), 32'd1);
    repeat (done_dly) @(posedge clk);
    #1 bus.acc_done = 1'b1;

    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.job_done) begin
        seen = 1'b1;
        break;
      end
      if (abort_after > 0 && pop_cnt >= abort_after) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_glb_re", 32'(bus.glb_re), 32'd0);
        check_eq("abort_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        exp_r_addr.delete();
        exp_out.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.acc_done  = 1'b0;
        bus.out_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.out_ready = rdy_pat[3 - ((k + 1) % 4)];
    end
    check_eq("job_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus.acc_done  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check_eq("acc_start_pulses", 32'(start_cnt), 32'd1);
    check_eq("job_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("write_count", 32'(we_cnt), 32'(lw));
    check_eq("read_count", 32'(re_cnt), 32'(dw));
    check_eq("pop_count", 32'(pop_cnt), 32'(dw));
    check_eq("queues_empty",
             32'(exp_w_addr.size() + exp_r_addr.size() + exp_out.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.load_base   = '0;
    bus.load_words  = '0;
    bus.drain_base  = '0;
    bus.drain_words = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    bus.acc_done    = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", bus.out_data, 32'd0);
    check_eq("rst_acc_start", 32'(bus.acc_start), 32'd0);
    check_eq("rst_job_done", 32'(bus.job_done), 32'd0);
    check_eq("rst_glb_we", 32'(bus.glb_we), 32'd0);
    check_eq("rst_glb_re", 32'(bus.glb_re), 32'd0);
    rst = 1'b0;

    // Load 0x11..0x44 at 0x100 on consecutive cycles.
    run_job(32'h100, 4, 32'h11, 32'h0, 0, 4'b1111, 2, 0);
    check_eq("load_span", 32'(last_we - first_we), 32'd3);

    // Drain 3 words from 0x200 with done 10 cycles after start.
    run_job(32'h0, 0, 32'h0, 32'h200, 3, 4'b1111, 10, 0);
    check_eq("read_span", 32'(last_re - first_re), 32'd2);
    check_eq("pop_span", 32'(last_pop - first_pop), 32'd2);
    check_eq("done_after_pop", 32'(done_cyc - last_pop), 32'd1);

    // Drain 8 words under out_ready 1,0,0,1 backpressure.
    run_job(32'h0, 0, 32'h0, 32'h400, 8, 4'b1001, 1, 0);

    // Empty job: no GLB traffic at all.
    run_job(32'h0, 0, 32'h0, 32'h0, 0, 4'b1111, 3, 0);

    // Reset mid-drain after 2 of 5 words, then a normal job.
    run_job(32'h80, 2, 32'h5, 32'h600, 5, 4'b1111, 1, 2);
    run_job(32'h140, 3, 32'h7, 32'h700, 4, 4'b1111, 1, 0);

    // Unaligned base and address wrap-around.
    run_job(32'h103, 2, 32'h9, 32'h0, 0, 4'b1111, 1, 0);
    run_job(32'hFFFF_FFFC, 2, 32'h3, 32'h0, 0, 4'b1111, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
